// File: rtl/wic_cmd_sequencer_pkg.sv
// Shared definitions for the WIC command sequencer: FSM states, stage IDs
// and error-code helpers.
package wic_cmd_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ACCUM  = 4'd1,
      ST_DEC_S  = 4'd2,
      ST_DEC_W  = 4'd3,
      ST_OTP_S  = 4'd4,
      ST_OTP_W  = 4'd5,
      ST_BLE_S  = 4'd6,
      ST_BLE_W  = 4'd7,
      ST_SPI_LD = 4'd8,
      ST_SPI_W  = 4'd9,
      ST_DONE   = 4'd10,
      ST_ERR    = 4'd11
   } seq_state_e;

   localparam logic [2:0] STAGE_ACCUM = 3'd1;
   localparam logic [2:0] STAGE_DEC   = 3'd2;
   localparam logic [2:0] STAGE_OTP   = 3'd3;
   localparam logic [2:0] STAGE_BLE   = 3'd4;
   localparam logic [2:0] STAGE_SPI   = 3'd5;

   // Abort uses stage 7, which no real stage occupies, so it can never be
   // confused with a submodule error or a timeout.
   localparam logic [3:0] ERR_ABORT   = 4'b0111;

   // err_code layout: {timeout flag, stage id}
   function automatic logic [3:0] err_of(input logic timeout, input logic [2:0] stage);
      return {timeout, stage};
   endfunction

endpackage

// File: rtl/wic_cmd_sequencer_stage_watchdog.sv
// Per-stage watchdog. Reloads on every state entry and counts down while the
// sequencer sits in a waiting state; expires once STAGE_TIMEOUT-1 cycles have
// been counted, so the stage is left after STAGE_TIMEOUT cycles in total.
module wic_cmd_sequencer_stage_watchdog #(
   parameter int STAGE_TIMEOUT = 2000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(STAGE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STAGE_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Down-counter: reload on clear, decrement while enabled, stop at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= LOAD_VAL;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/wic_cmd_sequencer.sv
// WIC command sequencer: walks one command through the UART accumulator,
// host command decoder, OTP block and bluetooth encoder, then streams the
// encoder payload MSB-byte-first to the SPI master.
//
// state  | meaning
// IDLE   | waiting for a UART byte to start a command
// ACCUM  | accumulator collecting the command
// DEC_S  | one-cycle decoder start
// DEC_W  | waiting for decoder done/error
// OTP_S  | one-cycle OTP start
// OTP_W  | waiting for OTP done
// BLE_S  | one-cycle encoder start
// BLE_W  | waiting for encoder done, payload captured on exit
// SPI_LD | waiting for SPI ready, then presents next byte
// SPI_W  | waiting for SPI byte-complete
// DONE   | one-cycle seq_done pulse
// ERR    | one-cycle seq_error pulse
module wic_cmd_sequencer
   import wic_cmd_sequencer_pkg::*;
#(
   parameter int PAYLOAD_BYTES = 18,
   parameter int STAGE_TIMEOUT = 2000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mode,
   input  logic         abort,
   input  logic         uart_valid,
   output logic         accumulate,
   input  logic         accum_done,
   input  logic         accum_error,
   output logic         dec_start,
   input  logic         dec_done,
   input  logic         dec_error,
   output logic         otp_start,
   output logic         otp_passthru,
   input  logic         otp_done,
   output logic         ble_start,
   input  logic         ble_done,
   input  logic [143:0] ble_data,
   output logic [7:0]   spi_tx_byte,
   output logic         spi_tx_dv,
   input  logic         spi_tx_ready,
   input  logic         spi_rx_dv,
   output logic         busy,
   output logic         seq_done,
   output logic         seq_error,
   output logic [3:0]   err_code
);

   localparam int PAYLOAD_W = 8 * PAYLOAD_BYTES;
   localparam int BCNT_W    = $clog2(PAYLOAD_BYTES + 1);

   seq_state_e            state;
   seq_state_e            state_nxt;
   logic [3:0]            err_sel;
   logic [PAYLOAD_W-1:0]  shreg;
   logic [BCNT_W-1:0]     byte_cnt;
   logic                  wd_clear;
   logic                  wd_enable;
   logic                  wd_expired;
   logic                  abortable;

   assign wd_clear  = (state_nxt != state);
   assign wd_enable = state inside {ST_ACCUM, ST_DEC_W, ST_OTP_W, ST_BLE_W, ST_SPI_LD, ST_SPI_W};
   // DONE and ERR already report the outcome; abort there would double-report.
   assign abortable = !(state inside {ST_IDLE, ST_DONE, ST_ERR});

   wic_cmd_sequencer_stage_watchdog #(
      .STAGE_TIMEOUT (STAGE_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Next-state decode; within a state: error > done > timeout, abort overrides all.
   always_comb begin
      state_nxt = state;
      err_sel   = '0;
      case (state)
         ST_IDLE: begin
            if (uart_valid) state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (accum_error) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b0, STAGE_ACCUM);
            end else if (accum_done) begin
               state_nxt = ST_DEC_S;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_ACCUM);
            end
         end
         ST_DEC_S: state_nxt = ST_DEC_W;
         ST_DEC_W: begin
            if (dec_error) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b0, STAGE_DEC);
            end else if (dec_done) begin
               state_nxt = ST_OTP_S;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_DEC);
            end
         end
         ST_OTP_S: state_nxt = ST_OTP_W;
         ST_OTP_W: begin
            if (otp_done) begin
               state_nxt = ST_BLE_S;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_OTP);
            end
         end
         ST_BLE_S: state_nxt = ST_BLE_W;
         ST_BLE_W: begin
            if (ble_done) begin
               state_nxt = ST_SPI_LD;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_BLE);
            end
         end
         ST_SPI_LD: begin
            if (spi_tx_ready) begin
               state_nxt = ST_SPI_W;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_SPI);
            end
         end
         ST_SPI_W: begin
            if (spi_rx_dv) begin
               state_nxt = (byte_cnt == BCNT_W'(1)) ? ST_DONE : ST_SPI_LD;
            end else if (wd_expired) begin
               state_nxt = ST_ERR;
               err_sel   = err_of(1'b1, STAGE_SPI);
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (abort && abortable) begin
         state_nxt = ST_ERR;
         err_sel   = ERR_ABORT;
      end
   end

   // State register, registered outputs decoded from the upcoming state, payload shifter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         accumulate   <= 1'b0;
         dec_start    <= 1'b0;
         otp_start    <= 1'b0;
         ble_start    <= 1'b0;
         otp_passthru <= 1'b0;
         spi_tx_byte  <= '0;
         spi_tx_dv    <= 1'b0;
         busy         <= 1'b0;
         seq_done     <= 1'b0;
         seq_error    <= 1'b0;
         err_code     <= '0;
         shreg        <= '0;
         byte_cnt     <= '0;
      end else begin
         state      <= state_nxt;
         busy       <= (state_nxt != ST_IDLE);
         accumulate <= (state_nxt == ST_ACCUM);
         dec_start  <= (state_nxt == ST_DEC_S);
         otp_start  <= (state_nxt == ST_OTP_S);
         ble_start  <= (state_nxt == ST_BLE_S);
         seq_done   <= (state_nxt == ST_DONE);
         seq_error  <= (state_nxt == ST_ERR);
         spi_tx_dv  <= (state == ST_SPI_LD) && (state_nxt == ST_SPI_W);

         if ((state == ST_SPI_LD) && (state_nxt == ST_SPI_W)) begin
            spi_tx_byte <= shreg[PAYLOAD_W-1 -: 8];
         end

         if ((state == ST_IDLE) && (state_nxt == ST_ACCUM)) begin
            otp_passthru <= ~mode;
            err_code     <= '0;
         end

         if ((state_nxt == ST_ERR) && (state != ST_ERR)) begin
            err_code <= err_sel;
         end

         if ((state == ST_BLE_W) && (state_nxt == ST_SPI_LD)) begin
            shreg    <= ble_data;
            byte_cnt <= BCNT_W'(PAYLOAD_BYTES);
         end else if ((state == ST_SPI_W) && spi_rx_dv && (state_nxt != ST_ERR)) begin
            shreg    <= {shreg[PAYLOAD_W-9:0], 8'h00};
            byte_cnt <= byte_cnt - 1'b1;
         end
      end
   end

endmodule
